// File: rtl/fifo_wr_arb_pkg.sv
`default_nettype none
// =====================================================================
// fifo_wr_arb_pkg : shared encodings for the two-requester FIFO write arbiter
// Rev 1.0
// =====================================================================
package fifo_wr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [1:0] c_GRANT_NONE = 2'b00;
  localparam logic [1:0] c_GRANT_REQ0 = 2'b01;
  localparam logic [1:0] c_GRANT_REQ1 = 2'b10;

  localparam int WR_COUNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_select.sv
`default_nettype none
// =====================================================================
// rr_select : two-way round-robin winner pick (tie goes to rr_ptr)
// Rev 1.0
// =====================================================================
module rr_select (
  input  logic v0,
  input  logic v1,
  input  logic rr_ptr,
  output logic winner,
  output logic any_valid
);

  assign any_valid = v0 | v1;
  assign winner    = (v0 & v1) ? rr_ptr : v1;

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// =====================================================================
// fifo_wr_arbiter : round-robin burst arbiter feeding one FIFO write port
// Rev 1.0
// =====================================================================
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ADDRBITS = 4
) (
  input  logic                  w_clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [WIDTH-1:0]      req0_data,
  input  logic                  req0_last,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [WIDTH-1:0]      req1_data,
  input  logic                  req1_last,
  output logic                  req1_ready,
  input  logic                  f_flag,
  output logic                  wen,
  output logic [WIDTH-1:0]      wdata,
  output logic [1:0]            grant,
  output logic [WR_COUNT_W-1:0] wr_count
);

  localparam int MAX_BURST = 2 ** ADDRBITS;
  localparam logic [ADDRBITS:0] c_MAX_BEAT = MAX_BURST[ADDRBITS:0];

  state_t                  r_state;
  logic                    r_rr_ptr;
  logic [ADDRBITS:0]       r_beat;
  logic [WR_COUNT_W-1:0]   r_wr_count;

  logic                    w_gnt0;
  logic                    w_gnt1;
  logic                    w_sel_valid;
  logic                    w_sel_last;
  logic                    w_other_valid;
  logic                    w_wen;
  logic [ADDRBITS:0]       w_beat_next;
  logic                    w_burst_end;
  logic                    w_winner;
  logic                    w_any_valid;
  logic [WIDTH-1:0]        w_wdata;

  rr_select u_rr_select (
    .v0        (req0_valid),
    .v1        (req1_valid),
    .rr_ptr    (r_rr_ptr),
    .winner    (w_winner),
    .any_valid (w_any_valid)
  );

  assign w_gnt0        = (r_state == GRANT0);
  assign w_gnt1        = (r_state == GRANT1);
  assign w_sel_valid   = (w_gnt0 & req0_valid) | (w_gnt1 & req1_valid);
  assign w_sel_last    = (w_gnt0 & req0_last)  | (w_gnt1 & req1_last);
  assign w_other_valid = (w_gnt0 & req1_valid) | (w_gnt1 & req0_valid);

  // A full FIFO blocks the handshake entirely, so last under f_flag cannot end a burst
  assign w_wen       = w_sel_valid & ~f_flag;
  assign w_beat_next = r_beat + 1'b1;
  assign w_burst_end = w_wen & (w_sel_last | (w_beat_next == c_MAX_BEAT));

  always_comb begin
    w_wdata = '0;
    if (w_gnt0)
      w_wdata = req0_data;
    else if (w_gnt1)
      w_wdata = req1_data;
  end

  always_ff @(posedge w_clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= 1'b0;
      r_beat     <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_wen)
        r_wr_count <= r_wr_count + 1'b1;
      case (r_state)
        IDLE: begin
          if (w_any_valid)
            r_state <= w_winner ? GRANT1 : GRANT0;
        end
        GRANT0, GRANT1: begin
          if (w_burst_end) begin
            r_beat   <= '0;
            r_rr_ptr <= w_gnt0;
            // Hand straight over to a waiting peer to avoid an idle bubble
            if (w_other_valid)
              r_state <= w_gnt0 ? GRANT1 : GRANT0;
            else
              r_state <= IDLE;
          end else if (w_wen) begin
            r_beat <= w_beat_next;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req0_ready = w_gnt0 & ~f_flag;
  assign req1_ready = w_gnt1 & ~f_flag;
  assign wen        = w_wen;
  assign wdata      = w_wdata;
  assign wr_count   = r_wr_count;
  assign grant      = w_gnt0 ? c_GRANT_REQ0 : (w_gnt1 ? c_GRANT_REQ1 : c_GRANT_NONE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// =====================================================================
// tb_fifo_wr_arbiter : directed vector bench for fifo_wr_arbiter
// Rev 1.0
// =====================================================================
module tb_fifo_wr_arbiter;

  logic        w_clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_data = '0;
  logic        req0_last = 1'b0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_data = '0;
  logic        req1_last = 1'b0;
  logic        req1_ready;
  logic        f_flag = 1'b0;
  logic        wen;
  logic [31:0] wdata;
  logic [1:0]  grant;
  logic [15:0] wr_count;

  int passed = 0;
  int total  = 0;

  fifo_wr_arbiter #(.WIDTH(32), .ADDRBITS(4)) dut (
    .w_clk      (w_clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .f_flag     (f_flag),
    .wen        (wen),
    .wdata      (wdata),
    .grant      (grant),
    .wr_count   (wr_count)
  );

  always #5 w_clk = ~w_clk;

  typedef struct packed {
    logic        rst;
    logic        v0;
    logic [31:0] d0;
    logic        l0;
    logic        v1;
    logic [31:0] d1;
    logic        l1;
    logic        full;
    logic [1:0]  g;
    logic        we;
    logic [31:0] wd;
    logic        r0;
    logic        r1;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic v0, input logic [31:0] d0,
                              input logic l0, input logic v1, input logic [31:0] d1,
                              input logic l1, input logic full, input logic [1:0] g,
                              input logic we, input logic [31:0] wd, input logic r0,
                              input logic r1, input logic [15:0] cnt);
    vec_t v;
    v = '{rst, v0, d0, l0, v1, d1, l1, full, g, we, wd, r0, r1, cnt};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 0; req0_data = '0; req0_last = 0;
    req1_valid = 0; req1_data = '0; req1_last = 0;
    f_flag = 0;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [52:0] obs();
    return {grant, wen, wdata, req0_ready, req1_ready, wr_count};
  endfunction

  initial begin
    // Single-requester 3-beat burst
    vecs.push_back(mk(1, 0,32'h0,0,          0,32'h0,0, 0, 2'b00,0,32'h0,0,0,16'd0));
    vecs.push_back(mk(0, 1,32'hA5A5_0001,0,  0,32'h0,0, 0, 2'b00,0,32'h0,0,0,16'd0));
    vecs.push_back(mk(0, 1,32'hA5A5_0001,0,  0,32'h0,0, 0, 2'b01,1,32'hA5A5_0001,1,0,16'd0));
    vecs.push_back(mk(0, 1,32'hA5A5_0002,0,  0,32'h0,0, 0, 2'b01,1,32'hA5A5_0002,1,0,16'd1));
    vecs.push_back(mk(0, 1,32'hA5A5_0003,1,  0,32'h0,0, 0, 2'b01,1,32'hA5A5_0003,1,0,16'd2));
    vecs.push_back(mk(0, 0,32'h0,0,          0,32'h0,0, 0, 2'b00,0,32'h0,0,0,16'd3));
    // Simultaneous requests, back-to-back hand-over, pointer returns to req0
    vecs.push_back(mk(1, 0,32'h0,0,  0,32'h0,0,  0, 2'b00,0,32'h0,0,0,16'd0));
    vecs.push_back(mk(0, 1,32'hB0,0, 1,32'hC0,0, 0, 2'b00,0,32'h0,0,0,16'd0));
    vecs.push_back(mk(0, 1,32'hB0,0, 1,32'hC0,0, 0, 2'b01,1,32'hB0,1,0,16'd0));
    vecs.push_back(mk(0, 1,32'hB1,1, 1,32'hC0,0, 0, 2'b01,1,32'hB1,1,0,16'd1));
    vecs.push_back(mk(0, 0,32'h0,0,  1,32'hC0,0, 0, 2'b10,1,32'hC0,0,1,16'd2));
    vecs.push_back(mk(0, 0,32'h0,0,  1,32'hC1,1, 0, 2'b10,1,32'hC1,0,1,16'd3));
    vecs.push_back(mk(0, 0,32'h0,0,  0,32'h0,0,  0, 2'b00,0,32'h0,0,0,16'd4));
    vecs.push_back(mk(0, 1,32'hB2,1, 1,32'hC2,1, 0, 2'b00,0,32'h0,0,0,16'd4));
    vecs.push_back(mk(0, 1,32'hB2,1, 1,32'hC2,1, 0, 2'b01,1,32'hB2,1,0,16'd4));
    vecs.push_back(mk(0, 0,32'h0,0,  1,32'hC2,1, 0, 2'b10,1,32'hC2,0,1,16'd5));
    vecs.push_back(mk(0, 0,32'h0,0,  0,32'h0,0,  0, 2'b00,0,32'h0,0,0,16'd6));
    // Valid gap and FIFO full with last asserted mid-burst
    vecs.push_back(mk(0, 1,32'hD0,0, 0,32'h0,0,  0, 2'b00,0,32'h0,0,0,16'd6));
    vecs.push_back(mk(0, 1,32'hD0,0, 0,32'h0,0,  0, 2'b01,1,32'hD0,1,0,16'd6));
    vecs.push_back(mk(0, 0,32'h0,0,  0,32'h0,0,  0, 2'b01,0,32'h0,1,0,16'd7));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 1,32'hD1,1, 1,32'hE0,1, 1, 2'b01,0,32'hD1,0,0,16'd7));
    vecs.push_back(mk(0, 1,32'hD1,1, 1,32'hE0,1, 0, 2'b01,1,32'hD1,1,0,16'd7));
    vecs.push_back(mk(0, 0,32'h0,0,  1,32'hE0,1, 0, 2'b10,1,32'hE0,0,1,16'd8));
    vecs.push_back(mk(0, 0,32'h0,0,  0,32'h0,0,  0, 2'b00,0,32'h0,0,0,16'd9));

    #1;
    foreach (vecs[i]) begin
      reset      = vecs[i].rst;
      req0_valid = vecs[i].v0; req0_data = vecs[i].d0; req0_last = vecs[i].l0;
      req1_valid = vecs[i].v1; req1_data = vecs[i].d1; req1_last = vecs[i].l1;
      f_flag     = vecs[i].full;
      #2;
      check($sformatf("vec%0d", i), 64'(obs()),
            64'({vecs[i].g, vecs[i].we, vecs[i].wd, vecs[i].r0, vecs[i].r1, vecs[i].cnt}));
      step();
    end

    // Burst cap: req1 streams without last, gets cut at 16 beats
    do_reset();
    req1_valid = 1; req1_data = 32'd100;
    #2;
    check("cap_idle", 64'(grant), 64'(2'b00));
    step();
    req0_valid = 1; req0_data = 32'd200; req0_last = 1;
    for (int i = 0; i < 16; i++) begin
      req1_data = 32'(100 + i);
      #2;
      check($sformatf("cap_beat%0d", i), 64'({grant, wen, wdata}), 64'({2'b10, 1'b1, 32'(100 + i)}));
      step();
    end
    #2;
    check("cap_req0", 64'({grant, wen, wdata}), 64'({2'b01, 1'b1, 32'd200}));
    step();
    req0_valid = 0; req0_last = 0;
    for (int i = 16; i < 20; i++) begin
      req1_data = 32'(100 + i);
      req1_last = (i == 19);
      #2;
      check($sformatf("cap_resume%0d", i), 64'({grant, wen, wdata}), 64'({2'b10, 1'b1, 32'(100 + i)}));
      step();
    end
    req1_valid = 0; req1_last = 0;
    #2;
    check("cap_done", 64'({grant, wr_count}), 64'({2'b00, 16'd21}));

    // Asynchronous reset in the middle of a GRANT1 burst
    step();
    do_reset();
    req1_valid = 1; req1_data = 32'h11;
    step();
    step();
    req1_data = 32'h12;
    #2;
    check("arst_beat2", 64'({grant, wen, wdata, wr_count}), 64'({2'b10, 1'b1, 32'h12, 16'd1}));
    #1 reset = 1'b1;
    #1;
    check("arst_now", 64'(obs()), 64'(53'd0));
    step();
    reset = 1'b0;
    req0_valid = 1; req0_data = 32'h21; req0_last = 1;
    req1_data = 32'h13; req1_last = 1;
    #2;
    check("arst_release", 64'(obs()), 64'(53'd0));
    step();
    #2;
    check("arst_tie", 64'({grant, wdata}), 64'({2'b01, 32'h21}));
    step();

    // Counter wrap through back-to-back single-beat bursts
    do_reset();
    req0_valid = 1; req0_last = 1;
    req1_valid = 1; req1_last = 1;
    for (int n = 0; n < 65537; n++) step();
    check("wrap_zero", 64'(wr_count), 64'(16'd0));
    step();
    check("wrap_one", 64'(wr_count), 64'(16'd1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
